// File: rtl/maj21_vote_if.sv
// Handshake and result bundle between the vote collector and its environment.
// The master side supplies votes and accepts frames. The slave side is the collector.
interface maj21_vote_if #(
    parameter int N = 21
);
    logic         in_valid;
    logic         in_bit;
    logic         in_ready;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] x;
    logic [4:0]   ones;
    logic         maj;
    logic [7:0]   frames;

    modport master (
        output in_valid,
        output in_bit,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  x,
        input  ones,
        input  maj,
        input  frames
    );

    modport slave (
        input  in_valid,
        input  in_bit,
        input  out_ready,
        output in_ready,
        output out_valid,
        output x,
        output ones,
        output maj,
        output frames
    );
endinterface

// File: rtl/maj21_vote_collector.sv
// Serial vote collector: gathers N single-bit votes into a parallel vector.
// It presents the vector, its popcount and a registered majority decision
// until downstream takes the frame. abort discards the frame in progress
// or the frame on hold, and leaves the completed-frame counter untouched.
module maj21_vote_collector #(
    parameter int N      = 21,
    parameter int THRESH = 11
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           abort,
    maj21_vote_if.slave    bus
);
    // idx and ones are 5 bits wide, so a frame can hold at most 31 votes.
    if (N < 1 || N > 31) begin : g_bad_n
        $error("maj21_vote_collector: N must be in 1..31");
    end

    localparam logic [0:0] COLLECT = 1'b0;
    localparam logic [0:0] HOLD    = 1'b1;
    localparam logic [4:0] LAST    = 5'(N - 1);

    logic [0:0]   state_reg,  state_next;
    logic [4:0]   idx_reg,    idx_next;
    logic [4:0]   ones_reg,   ones_next;
    logic         maj_reg,    maj_next;
    logic [7:0]   frames_reg, frames_next;
    logic [N-1:0] x_reg,      x_next;

    logic         accept;
    logic         handshake;
    logic         clear_frame;
    logic [4:0]   ones_inc;

    // A vote is taken only while collecting. A frame leaves only while held.
    assign accept      = bus.in_valid  && (state_reg == COLLECT);
    assign handshake   = bus.out_ready && (state_reg == HOLD);
    assign clear_frame = abort || handshake;
    assign ones_inc    = ones_reg + {4'b0000, bus.in_bit};

    // Each vector bit loads the current vote only when idx points at it.
    // All bits drop together when the frame is cleared.
    for (genvar gi = 0; gi < N; gi++) begin : g_xbit
        assign x_next[gi] = clear_frame                          ? 1'b0       :
                            (accept && (idx_reg == 5'(gi)))      ? bus.in_bit :
                                                                   x_reg[gi];
    end

    // Next-state logic. abort overrides both the vote accept and the output handshake.
    always_comb begin
        state_next  = state_reg;
        idx_next    = idx_reg;
        ones_next   = ones_reg;
        maj_next    = maj_reg;
        frames_next = frames_reg;
        if (abort) begin
            state_next = COLLECT;
            idx_next   = 5'd0;
            ones_next  = 5'd0;
            maj_next   = 1'b0;
        end else begin
            case (state_reg)
                COLLECT: begin
                    if (accept) begin
                        ones_next = ones_inc;
                        if (idx_reg == LAST) begin
                            // The decision is captured on the edge that enters HOLD.
                            // It stays frozen until the frame is released.
                            state_next = HOLD;
                            idx_next   = 5'd0;
                            maj_next   = (int'(ones_inc) >= THRESH);
                        end else begin
                            idx_next = idx_reg + 5'd1;
                        end
                    end
                end
                HOLD: begin
                    if (handshake) begin
                        state_next  = COLLECT;
                        idx_next    = 5'd0;
                        ones_next   = 5'd0;
                        maj_next    = 1'b0;
                        frames_next = frames_reg + 8'd1;
                    end
                end
                default: begin
                    state_next = COLLECT;
                end
            endcase
        end
    end

    // State registers. rst has priority over abort and over every handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= COLLECT;
            idx_reg    <= 5'd0;
            ones_reg   <= 5'd0;
            maj_reg    <= 1'b0;
            frames_reg <= 8'd0;
            x_reg      <= '0;
        end else begin
            state_reg  <= state_next;
            idx_reg    <= idx_next;
            ones_reg   <= ones_next;
            maj_reg    <= maj_next;
            frames_reg <= frames_next;
            x_reg      <= x_next;
        end
    end

    assign bus.in_ready  = (state_reg == COLLECT);
    assign bus.out_valid = (state_reg == HOLD);
    assign bus.x         = x_reg;
    assign bus.ones      = ones_reg;
    assign bus.maj       = maj_reg;
    assign bus.frames    = frames_reg;
endmodule

// File: tb/tb_maj21_vote_collector.sv
// Randomised and directed bench for maj21_vote_collector.
// Completed frames go through a scoreboard queue, and a separate monitor
// checks them. A queue-of-votes model also checks every output on every cycle.
module tb_maj21_vote_collector;
    localparam int N = 21;
    localparam int T = 11;

    typedef struct {
        logic [N-1:0] x;
        int           ones;
        logic         maj;
        int           frames;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic abort;
    always #5 clk = ~clk;

    maj21_vote_if #(.N(N)) bus();

    maj21_vote_collector #(.N(N), .THRESH(T)) dut (
        .clk   (clk),
        .rst   (rst),
        .abort (abort),
        .bus   (bus)
    );

    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];

    // Reference model: the accepted votes of the current frame, in arrival order.
    bit       bits_q[$];
    bit       model_hold = 1'b0;
    bit       model_ok   = 1'b0;
    int       model_frames = 0;
    int       total_frames = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] model_x();
        logic [N-1:0] r = '0;
        foreach (bits_q[i]) r[i] = bits_q[i];
        return r;
    endfunction

    function automatic int model_ones();
        int c = 0;
        foreach (bits_q[i]) c += int'(bits_q[i]);
        return c;
    endfunction

    // One clock of stimulus. The task checks the visible state against the
    // model, crosses the edge, then advances the model.
    task automatic step(input bit v, input bit b, input bit ordy, input bit ab, input bit rs);
        exp_t e;
        rst = rs; abort = ab;
        bus.in_valid = v; bus.in_bit = b; bus.out_ready = ordy;
        if (model_ok) begin
            check("in_ready",  32'(bus.in_ready),  32'(!model_hold));
            check("out_valid", 32'(bus.out_valid), 32'(model_hold));
            check("x",         32'(bus.x),         32'(model_x()));
            check("ones",      32'(bus.ones),      32'(model_ones()));
            check("maj",       32'(bus.maj),       32'(model_hold && (model_ones() >= T)));
            check("frames",    32'(bus.frames),    32'(model_frames % 256));
        end
        @(posedge clk);
        if (rs) begin
            bits_q.delete(); model_hold = 0; model_frames = 0; model_ok = 1;
        end else if (ab) begin
            bits_q.delete(); model_hold = 0;
        end else if (model_hold) begin
            if (ordy) begin
                bits_q.delete(); model_hold = 0;
                model_frames++; total_frames++;
            end
        end else if (v) begin
            bits_q.push_back(b);
            if (bits_q.size() == N) begin
                e.x = model_x(); e.ones = model_ones();
                e.maj = (e.ones >= T); e.frames = model_frames % 256;
                exp_q.push_back(e);
                model_hold = 1;
            end
        end
        #1;
    endtask

    task automatic send_frame(input logic [N-1:0] p);
        for (int k = 0; k < N; k++) step(1'b1, p[k], 1'b0, 1'b0, 1'b0);
    endtask

    // Scoreboard monitor: pops one expectation each time a frame appears and
    // checks it on every cycle the frame stays presented.
    initial begin : monitor
        bit   armed = 1'b1;
        bit   have  = 1'b0;
        exp_t cur;
        forever begin
            @(negedge clk);
            if (bus.out_valid === 1'b0) begin
                armed = 1'b1;
                have  = 1'b0;
            end else if (bus.out_valid === 1'b1) begin
                if (armed) begin
                    armed = 1'b0;
                    check("sb_pending", 32'(exp_q.size() > 0), 32'd1);
                    if (exp_q.size() > 0) begin
                        cur  = exp_q.pop_front();
                        have = 1'b1;
                    end
                end
                if (have) begin
                    check("sb_x",      32'(bus.x),      32'(cur.x));
                    check("sb_ones",   32'(bus.ones),   32'(cur.ones));
                    check("sb_maj",    32'(bus.maj),    32'(cur.maj));
                    check("sb_frames", 32'(bus.frames), 32'(cur.frames));
                end
            end
        end
    end

    initial begin : stim
        int cycles;
        int start_frames;
        int f0;
        rst = 1'b1; abort = 1'b0;
        bus.in_valid = 1'b0; bus.in_bit = 1'b0; bus.out_ready = 1'b0;
        @(posedge clk); #1;
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_frames",   32'(bus.frames),   32'd0);

        // Eleven ones followed by ten zeros is a bare majority.
        send_frame(21'h0007FF);
        check("r34_valid", 32'(bus.out_valid), 32'd1);
        check("r34_x",     32'(bus.x),         32'h0007FF);
        check("r34_ones",  32'(bus.ones),      32'd11);
        check("r34_maj",   32'(bus.maj),       32'd1);
        step(0, 0, 1, 0, 0);

        // Ten ones is one short of the majority. Release the frame and check the counter.
        step(0, 0, 0, 0, 1);
        send_frame(21'h0003FF);
        check("r35_ones", 32'(bus.ones), 32'd10);
        check("r35_maj",  32'(bus.maj),  32'd0);
        step(0, 0, 1, 0, 0);
        check("r35_valid",  32'(bus.out_valid), 32'd0);
        check("r35_x",      32'(bus.x),         32'd0);
        check("r35_frames", 32'(bus.frames),    32'd1);

        // Hold the frame under back-pressure while votes keep arriving.
        send_frame(21'($urandom));
        for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 0);
        check("r36_in_ready", 32'(bus.in_ready), 32'd0);
        step(0, 0, 1, 0, 0);
        step(1, 1, 0, 0, 0);
        check("r36_x0", 32'(bus.x), 32'd1);

        // Abort a partial frame, then abort a held frame as it is being released.
        f0 = int'(bus.frames);
        for (int i = 0; i < 6; i++) step(1, 1'($urandom), 0, 0, 0);
        step(0, 0, 0, 1, 0);
        check("r37_ones",   32'(bus.ones),   32'd0);
        check("r37_x",      32'(bus.x),      32'd0);
        check("r37_frames", 32'(bus.frames), 32'(f0));
        send_frame(21'($urandom));
        step(0, 0, 1, 1, 0);
        check("r37_hold_frames", 32'(bus.frames),    32'(f0));
        check("r37_hold_valid",  32'(bus.out_valid), 32'd0);

        // Run 256 frames from reset so the frame counter wraps back to zero.
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 256; i++) begin
            send_frame(21'($urandom));
            step(0, 0, 1, 0, 0);
        end
        check("r38_wrap", 32'(bus.frames), 32'd0);
        send_frame(21'($urandom));
        step(1, 1, 1, 0, 1);
        check("r38_rst_valid",  32'(bus.out_valid), 32'd0);
        check("r38_rst_frames", 32'(bus.frames),    32'd0);

        // Random traffic: gaps on both sides and occasional aborts.
        start_frames = total_frames;
        cycles = 0;
        while ((total_frames - start_frames) < 1500 && cycles < 70000) begin
            step(($urandom_range(3, 0) != 0), 1'($urandom),
                 1'($urandom), ($urandom_range(199, 0) == 0), 1'b0);
            cycles++;
        end
        check("rand_budget", 32'(cycles < 70000), 32'd1);

        // Drain any frame still on hold, then make sure nothing is left pending.
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
